// File: rtl/tinyalu_issuer_if.sv
// Command, ALU-pin and response signal bundle for tinyalu_issuer.
// slave: the issuer side. master: the command source, ALU and response consumer.
interface tinyalu_issuer_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [7:0]  cmd_a;
   logic [7:0]  cmd_b;
   logic [2:0]  cmd_op;

   logic [7:0]  alu_a;
   logic [7:0]  alu_b;
   logic [2:0]  alu_op;
   logic        alu_start;
   logic        alu_reset_n;
   logic        alu_done;
   logic [15:0] alu_result;

   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_result;
   logic [2:0]  rsp_op;
   logic        rsp_timeout;

   logic        busy;

   modport slave (
      input  cmd_valid, cmd_a, cmd_b, cmd_op, alu_done, alu_result, rsp_ready,
      output cmd_ready, alu_a, alu_b, alu_op, alu_start, alu_reset_n,
             rsp_valid, rsp_result, rsp_op, rsp_timeout, busy
   );

   modport master (
      output cmd_valid, cmd_a, cmd_b, cmd_op, alu_done, alu_result, rsp_ready,
      input  cmd_ready, alu_a, alu_b, alu_op, alu_start, alu_reset_n,
             rsp_valid, rsp_result, rsp_op, rsp_timeout, busy
   );
endinterface

// File: rtl/tinyalu_issuer.sv
// Command issuer in front of the tiny ALU: queues commands in a small
// first-word-fall-through FIFO, drives the ALU start/done handshake, answers
// nops locally, times out commands whose done never arrives, and returns each
// result on a valid/ready response port.
module tinyalu_issuer #(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned TIMEOUT = 8
) (
   input  logic            clk,
   input  logic            reset,
   tinyalu_issuer_if.slave bus
);
   localparam int unsigned   AW       = $clog2(DEPTH);
   localparam int unsigned   CW       = $clog2(TIMEOUT);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {WAKE, IDLE, ISSUE, GAP} state_t;

   state_t        r_state, w_state_nxt;
   logic          r_wake_cnt, w_wake_cnt_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic [7:0]    r_alu_a, w_alu_a_nxt;
   logic [7:0]    r_alu_b, w_alu_b_nxt;
   logic [2:0]    r_alu_op, w_alu_op_nxt;
   logic          r_alu_start, w_alu_start_nxt;
   logic          r_alu_reset_n, w_alu_reset_n_nxt;
   logic          r_rsp_valid, w_rsp_valid_nxt;
   logic [15:0]   r_rsp_result, w_rsp_result_nxt;
   logic [2:0]    r_rsp_op, w_rsp_op_nxt;
   logic          r_rsp_timeout, w_rsp_timeout_nxt;

   // FIFO entry layout: {op[18:16], a[15:8], b[7:0]}
   logic [18:0]   r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr, r_rd_ptr;
   logic [AW:0]   r_count;

   logic          w_empty, w_full, w_cmd_ready, w_push, w_pop, w_launch_ok;
   logic [18:0]   w_head;

   assign w_empty     = (r_count == '0);
   assign w_full      = (r_count == FULL_CNT);
   assign w_cmd_ready = ~reset & ~w_full;
   assign w_push      = bus.cmd_valid & w_cmd_ready;
   assign w_head      = r_mem[r_rd_ptr];
   assign w_launch_ok = ~w_empty & r_alu_reset_n & (~r_rsp_valid | bus.rsp_ready);

   // Next-state and next-register values for the issue FSM and response slot.
   always_comb begin
      w_state_nxt       = r_state;
      w_wake_cnt_nxt    = r_wake_cnt;
      w_cnt_nxt         = r_cnt;
      w_alu_a_nxt       = r_alu_a;
      w_alu_b_nxt       = r_alu_b;
      w_alu_op_nxt      = r_alu_op;
      w_alu_start_nxt   = r_alu_start;
      w_alu_reset_n_nxt = r_alu_reset_n;
      w_rsp_valid_nxt   = r_rsp_valid;
      w_rsp_result_nxt  = r_rsp_result;
      w_rsp_op_nxt      = r_rsp_op;
      w_rsp_timeout_nxt = r_rsp_timeout;
      w_pop             = 1'b0;

      // A consumed response clears; any reload below overrides this.
      if (r_rsp_valid && bus.rsp_ready) begin
         w_rsp_valid_nxt = 1'b0;
      end

      case (r_state)
         WAKE: begin
            if (r_wake_cnt) begin
               w_alu_reset_n_nxt = 1'b1;
               w_state_nxt       = IDLE;
            end else begin
               w_wake_cnt_nxt = 1'b1;
            end
         end
         IDLE, GAP: begin
            w_state_nxt = IDLE;
            if (w_launch_ok) begin
               w_pop = 1'b1;
               if (w_head[18:16] != 3'b000) begin
                  w_alu_op_nxt    = w_head[18:16];
                  w_alu_a_nxt     = w_head[15:8];
                  w_alu_b_nxt     = w_head[7:0];
                  w_alu_start_nxt = 1'b1;
                  w_cnt_nxt       = '0;
                  w_state_nxt     = ISSUE;
               end else begin
                  w_rsp_result_nxt  = '0;
                  w_rsp_op_nxt      = 3'b000;
                  w_rsp_timeout_nxt = 1'b0;
                  w_rsp_valid_nxt   = 1'b1;
               end
            end
         end
         ISSUE: begin
            w_cnt_nxt = r_cnt + 1'b1;
            if (bus.alu_done) begin
               w_rsp_result_nxt  = bus.alu_result;
               w_rsp_op_nxt      = r_alu_op;
               w_rsp_timeout_nxt = 1'b0;
               w_rsp_valid_nxt   = 1'b1;
               w_alu_start_nxt   = 1'b0;
               w_state_nxt       = GAP;
            end else if (r_cnt == CNT_LAST) begin
               w_rsp_result_nxt  = '1;
               w_rsp_op_nxt      = r_alu_op;
               w_rsp_timeout_nxt = 1'b1;
               w_rsp_valid_nxt   = 1'b1;
               w_alu_start_nxt   = 1'b0;
               w_state_nxt       = GAP;
            end
         end
         default: w_state_nxt = WAKE;
      endcase
   end

   // State register and ALU/response registers; reset returns the FSM to WAKE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= WAKE;
         r_wake_cnt    <= 1'b0;
         r_cnt         <= '0;
         r_alu_a       <= '0;
         r_alu_b       <= '0;
         r_alu_op      <= '0;
         r_alu_start   <= 1'b0;
         r_alu_reset_n <= 1'b0;
         r_rsp_valid   <= 1'b0;
         r_rsp_result  <= '0;
         r_rsp_op      <= '0;
         r_rsp_timeout <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_wake_cnt    <= w_wake_cnt_nxt;
         r_cnt         <= w_cnt_nxt;
         r_alu_a       <= w_alu_a_nxt;
         r_alu_b       <= w_alu_b_nxt;
         r_alu_op      <= w_alu_op_nxt;
         r_alu_start   <= w_alu_start_nxt;
         r_alu_reset_n <= w_alu_reset_n_nxt;
         r_rsp_valid   <= w_rsp_valid_nxt;
         r_rsp_result  <= w_rsp_result_nxt;
         r_rsp_op      <= w_rsp_op_nxt;
         r_rsp_timeout <= w_rsp_timeout_nxt;
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // FIFO storage; contents need no reset since occupancy gates every read.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= {bus.cmd_op, bus.cmd_a, bus.cmd_b};
   end

   assign bus.cmd_ready   = w_cmd_ready;
   assign bus.alu_a       = r_alu_a;
   assign bus.alu_b       = r_alu_b;
   assign bus.alu_op      = r_alu_op;
   assign bus.alu_start   = r_alu_start;
   assign bus.alu_reset_n = r_alu_reset_n;
   assign bus.rsp_valid   = r_rsp_valid;
   assign bus.rsp_result  = r_rsp_result;
   assign bus.rsp_op      = r_rsp_op;
   assign bus.rsp_timeout = r_rsp_timeout;
   // WAKE is left out so busy reads 0 while reset holds the FSM there.
   assign bus.busy        = (r_state == ISSUE) || (r_state == GAP) || ~w_empty;
endmodule

// File: tb/tb_tinyalu_issuer.sv
// Directed bench for tinyalu_issuer with a behavioural tiny-ALU model.
module tb_tinyalu_issuer;
   logic        clk   = 1'b0;
   logic        reset = 1'b1;
   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   int unsigned cyc     = 0;
   int unsigned alu_mode = 0;   // 0: normal ALU, 1: done never asserted

   logic        m_done   = 1'b0;
   logic [15:0] m_result = '0;
   logic [2:0]  m_cnt    = '0;
   logic        start_d  = 1'b0;

   logic [19:0] rsp_q [$];
   int unsigned rise_cyc [$];

   tinyalu_issuer_if bus ();

   tinyalu_issuer #(.DEPTH(4), .TIMEOUT(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Tiny ALU: single-cycle ops raise done on every edge start is seen
   // (so done stays up 2 cycles), mult raises done on the 4th start edge.
   always @(posedge clk) begin
      if (!bus.alu_reset_n) begin
         m_done   <= 1'b0;
         m_cnt    <= '0;
         m_result <= '0;
      end else if (bus.alu_start && alu_mode == 0) begin
         if (bus.alu_op[2]) begin
            m_cnt    <= m_cnt + 3'd1;
            m_done   <= (m_cnt == 3'd3);
            m_result <= {8'h00, bus.alu_a} * {8'h00, bus.alu_b};
         end else begin
            m_done <= 1'b1;
            case (bus.alu_op[1:0])
               2'b01:   m_result <= {8'h00, bus.alu_a} + {8'h00, bus.alu_b};
               2'b10:   m_result <= {8'h00, bus.alu_a & bus.alu_b};
               default: m_result <= {8'h00, bus.alu_a ^ bus.alu_b};
            endcase
         end
      end else begin
         m_done <= 1'b0;
         m_cnt  <= '0;
      end
   end

   assign bus.alu_done   = m_done;
   assign bus.alu_result = m_result;

   // Response handshakes and alu_start rising edges.
   always @(posedge clk) begin
      if (!reset) begin
         if (bus.rsp_valid && bus.rsp_ready)
            rsp_q.push_back({bus.rsp_op, bus.rsp_timeout, bus.rsp_result});
         if (bus.alu_start && !start_d) rise_cyc.push_back(cyc);
      end
      start_d <= bus.alu_start;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
      int unsigned w = 0;
      while (!bus.cmd_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      chk("send_ready", 32'(bus.cmd_ready), 32'd1);
      bus.cmd_valid = 1'b1;
      bus.cmd_a     = a;
      bus.cmd_b     = b;
      bus.cmd_op    = op;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_valid(output int unsigned lat);
      lat = 0;
      while (!bus.rsp_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic chk_rsp(input string tag, input logic [15:0] r, input logic [2:0] op,
                          input logic to);
      int unsigned w = 0;
      logic [19:0] got;
      while (rsp_q.size() == 0 && w < 80) begin
         @(negedge clk);
         w++;
      end
      if (rsp_q.size() != 0) got = rsp_q.pop_front();
      else                   got = 'x;
      chk(tag, {12'h000, got}, {12'h000, op, to, r});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned lat;
      int unsigned base;
      int unsigned d1, d2;
      int unsigned bad;

      bus.cmd_valid = 1'b0;
      bus.cmd_a     = '0;
      bus.cmd_b     = '0;
      bus.cmd_op    = '0;
      bus.rsp_ready = 1'b1;

      // Reset state.
      repeat (2) @(negedge clk);
      chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      chk("rst_reset_n",   32'(bus.alu_reset_n), 32'd0);
      chk("rst_start",     32'(bus.alu_start), 32'd0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_busy",      32'(bus.busy), 32'd0);
      reset = 1'b0;
      #1;
      chk("wake_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      @(negedge clk);
      chk("wake_edge1_reset_n", 32'(bus.alu_reset_n), 32'd0);
      @(negedge clk);
      chk("wake_edge2_reset_n", 32'(bus.alu_reset_n), 32'd1);

      // Single add: 3 + 4, latency 3.
      send(8'h03, 8'h04, 3'b001);
      wait_valid(lat);
      chk("add_latency", lat, 32'd3);
      chk("add_result",  32'(bus.rsp_result), 32'h0007);
      chk("add_op",      32'(bus.rsp_op), 32'd1);
      chk("add_timeout", 32'(bus.rsp_timeout), 32'd0);
      repeat (3) @(negedge clk);
      rsp_q.delete();

      // Nop answered locally, latency 1, no start.
      base = rise_cyc.size();
      send(8'h12, 8'h34, 3'b000);
      wait_valid(lat);
      chk("nop_latency", lat, 32'd1);
      chk("nop_result",  32'(bus.rsp_result), 32'h0000);
      chk("nop_op",      32'(bus.rsp_op), 32'd0);
      repeat (3) @(negedge clk);
      chk("nop_no_start", rise_cyc.size() - base, 32'd0);
      rsp_q.delete();

      // Four back-to-back commands: mult, and, xor, nop.
      base = rise_cyc.size();
      send(8'hFF, 8'hFF, 3'b100);
      send(8'h0F, 8'hF0, 3'b010);
      send(8'hAA, 8'h55, 3'b011);
      send(8'h00, 8'h00, 3'b000);
      chk_rsp("b2b_rsp0", 16'hFE01, 3'b100, 1'b0);
      chk_rsp("b2b_rsp1", 16'h0000, 3'b010, 1'b0);
      chk_rsp("b2b_rsp2", 16'h00FF, 3'b011, 1'b0);
      chk_rsp("b2b_rsp3", 16'h0000, 3'b000, 1'b0);
      repeat (4) @(negedge clk);
      chk("b2b_starts", rise_cyc.size() - base, 32'd3);
      d1 = 0;
      d2 = 0;
      if (rise_cyc.size() >= base + 3) begin
         d1 = rise_cyc[base+1] - rise_cyc[base];
         d2 = rise_cyc[base+2] - rise_cyc[base+1];
      end
      chk("b2b_mult_spacing", d1, 32'd6);
      chk("b2b_single_spacing", d2, 32'd3);
      chk("b2b_idle_busy", 32'(bus.busy), 32'd0);
      rsp_q.delete();

      // Back-pressure: first response held, FIFO fills, no further launch.
      bus.rsp_ready = 1'b0;
      base = rise_cyc.size();
      send(8'h01, 8'h02, 3'b001);
      send(8'h05, 8'h06, 3'b001);
      send(8'h07, 8'h03, 3'b010);
      send(8'h0C, 8'h0A, 3'b011);
      send(8'h00, 8'h00, 3'b000);
      chk("full_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      chk("full_busy",      32'(bus.busy), 32'd1);
      chk("held_valid",     32'(bus.rsp_valid), 32'd1);
      chk("held_result",    32'(bus.rsp_result), 32'h0003);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 16'h0003 ||
             bus.rsp_op !== 3'b001 || bus.rsp_timeout !== 1'b0 || bus.cmd_ready !== 1'b0)
            bad++;
      end
      chk("held_frozen", bad, 32'd0);
      chk("held_one_start", rise_cyc.size() - base, 32'd1);
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      chk("pop_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      chk_rsp("drain_rsp0", 16'h0003, 3'b001, 1'b0);
      chk_rsp("drain_rsp1", 16'h000B, 3'b001, 1'b0);
      chk_rsp("drain_rsp2", 16'h0003, 3'b010, 1'b0);
      chk_rsp("drain_rsp3", 16'h0006, 3'b011, 1'b0);
      chk_rsp("drain_rsp4", 16'h0000, 3'b000, 1'b0);
      repeat (4) @(negedge clk);
      rsp_q.delete();

      // Timeout: ALU never raises done.
      alu_mode = 1;
      send(8'h01, 8'h01, 3'b001);
      wait_valid(lat);
      chk("to_latency", lat, 32'd9);
      chk("to_result",  32'(bus.rsp_result), 32'hFFFF);
      chk("to_flag",    32'(bus.rsp_timeout), 32'd1);
      chk("to_op",      32'(bus.rsp_op), 32'd1);
      repeat (2) @(negedge clk);
      alu_mode = 0;
      send(8'h02, 8'h03, 3'b001);
      wait_valid(lat);
      chk("after_to_latency", lat, 32'd3);
      chk("after_to_result",  32'(bus.rsp_result), 32'h0005);
      chk("after_to_flag",    32'(bus.rsp_timeout), 32'd0);
      repeat (4) @(negedge clk);
      rsp_q.delete();

      // Done held for 2 cycles: exactly one response.
      send(8'h1C, 8'h0F, 3'b010);
      repeat (12) @(negedge clk);
      chk("hold_count", rsp_q.size(), 32'd1);
      chk_rsp("hold_rsp", 16'h000C, 3'b010, 1'b0);

      // Reset during a mult's ISSUE with a second command queued.
      send(8'hFF, 8'h02, 3'b100);
      send(8'h11, 8'h22, 3'b001);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("mid_rst_start",     32'(bus.alu_start), 32'd0);
      chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("mid_rst_busy",      32'(bus.busy), 32'd0);
      chk("mid_rst_reset_n",   32'(bus.alu_reset_n), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      rsp_q.delete();
      repeat (2) @(negedge clk);
      chk("rewake_reset_n", 32'(bus.alu_reset_n), 32'd1);
      chk("rewake_busy",    32'(bus.busy), 32'd0);
      repeat (8) @(negedge clk);
      chk("rewake_no_rsp",  rsp_q.size(), 32'd0);
      send(8'h10, 8'h10, 3'b100);
      wait_valid(lat);
      chk("mult_latency", lat, 32'd6);
      chk("mult_result",  32'(bus.rsp_result), 32'h0100);
      chk("mult_op",      32'(bus.rsp_op), 32'd4);
      repeat (3) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
